// File: rtl/bit_cnt_pkg.sv
// Shared definitions for the round-robin popcount scheduler.
`timescale 1ns/1ps
package bit_cnt_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_DW   = 8;

    // Scheduler FSM: IDLE samples requests, COUNT runs the serial engine.
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Count width must hold the value DW itself (all-ones word).
    function automatic int cnt_w(input int dw);
        return $clog2(dw + 1);
    endfunction

    // Requester index width; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit1_cnt_core.sv
// Serial bit-1 counting engine: load a word, shift it out LSB first over
// DW cycles while accumulating ones, then pulse o_done with the sum.
`timescale 1ns/1ps
module bit1_cnt_core
    import bit_cnt_pkg::*;
#(
    parameter  int DW = DEF_DW,
    localparam int CW = cnt_w(DW)
) (
    input  logic          iclk,
    input  logic          irst,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    output logic          o_last,
    output logic          o_done,
    output logic [CW-1:0] o_sum
);

    logic [DW-1:0] shift_q;
    logic [CW-1:0] acc_q;
    logic [CW-1:0] cyc_q;
    logic          active_q;
    logic [CW-1:0] acc_next;

    // Sum including the bit currently at the bottom of the shifter.
    assign acc_next = acc_q + CW'(shift_q[0]);

    // High in the cycle whose bit is the last one of the word.
    assign o_last = active_q && (cyc_q == CW'(DW - 1));

    // Shifter, accumulator and cycle counter; o_done is a one-cycle pulse.
    always_ff @(posedge iclk) begin
        if (irst) begin
            shift_q  <= '0;
            acc_q    <= '0;
            cyc_q    <= '0;
            active_q <= 1'b0;
            o_done   <= 1'b0;
            o_sum    <= '0;
        end else begin
            o_done <= 1'b0;
            if (i_load) begin
                shift_q  <= i_data;
                acc_q    <= '0;
                cyc_q    <= '0;
                active_q <= 1'b1;
            end else if (active_q) begin
                acc_q   <= acc_next;
                shift_q <= {1'b0, shift_q[DW-1:1]};
                cyc_q   <= cyc_q + CW'(1);
                if (o_last) begin
                    active_q <= 1'b0;
                    o_done   <= 1'b1;
                    o_sum    <= acc_next;
                end
            end
        end
    end

endmodule

// File: rtl/bit_cnt_sched.sv
// Round-robin scheduler sharing one serial popcount engine among NREQ
// requesters; returns each count tagged with the requester index.
//
// Handshake: a requester holds i_req and its i_data word stable until it
// sees its o_gnt bit; the word is captured on the edge that raises o_gnt.
// The requester drops i_req in the o_gnt cycle or the one after; a level
// still high when the FSM is next IDLE counts as a new request. o_rsp_vld
// is a one-cycle pulse with no backpressure.
`timescale 1ns/1ps
module bit_cnt_sched
    import bit_cnt_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    parameter  int DW   = DEF_DW,
    localparam int CW   = cnt_w(DW),
    localparam int IW   = id_w(NREQ)
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ*DW-1:0] i_data,
    output logic [NREQ-1:0]    o_gnt,
    output logic               o_busy,
    output logic               o_rsp_vld,
    output logic [IW-1:0]      o_rsp_id,
    output logic [CW-1:0]      o_rsp_cnt
);

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   win;
    logic [IW-1:0]   idx;
    logic            found;
    logic            load;
    logic            core_last;
    logic [DW-1:0]   win_data;

    // Winner: first set request searching upward from ptr+1, wrapping.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(ptr_q) + i) % NREQ);
            if (!found && i_req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign win_data = i_data[win*DW +: DW];

    // Next-state logic; requests are only looked at while IDLE.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|i_req) begin
                    state_d = COUNT;
                    load    = 1'b1;
                end
            end
            COUNT: begin
                if (core_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge iclk) begin
        if (irst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Registered grant, busy flag, rr pointer and response tag.
    always_ff @(posedge iclk) begin
        if (irst) begin
            o_gnt    <= '0;
            o_busy   <= 1'b0;
            ptr_q    <= IW'(NREQ - 1);
            o_rsp_id <= '0;
        end else begin
            o_gnt  <= load ? (NREQ'(1) << win) : '0;
            o_busy <= (state_d == COUNT);
            if (load) ptr_q <= win;
            if ((state_q == COUNT) && core_last) o_rsp_id <= ptr_q;
        end
    end

    bit1_cnt_core #(.DW(DW)) u_core (
        .iclk   (iclk),
        .irst   (irst),
        .i_load (load),
        .i_data (win_data),
        .o_last (core_last),
        .o_done (o_rsp_vld),
        .o_sum  (o_rsp_cnt)
    );

endmodule
